// File: rtl/fifo_buffer_flags_pkg.sv
// Shared definitions for the single-clock flagged FIFO and its RAM.
// The read-mode constants and pointer-width helper are kept here so a later async FIFO can reuse them.
// No ports; compile-time constants and one elaboration-time helper only.
package fifo_buffer_flags_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int FIFO_STD  = 0;  // dout registered, valid one cycle after rd_en
  localparam int FIFO_FWFT = 1;  // head word shown on dout without a read request

  // Pointer width for a power-of-two depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_buffer_flags_ram.sv
// Simple dual-port storage: WIDTH x DEPTH, one synchronous write port and one read port.
// Read port is combinational (ASYNC_RD=1) or registered (ASYNC_RD=0) so a block-RAM primitive can replace it.
// Ports: i_clk, i_wr_en/i_waddr/i_wdata (write), i_raddr/o_rdata (read). Contents are never reset.
module fifo_buffer_flags_ram
  import fifo_buffer_flags_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int ASYNC_RD = 1,
  parameter int AW       = ptr_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  generate
    if (ASYNC_RD != 0) begin : g_async_rd
      // A read and write to the same address on one edge returns the old word.
      assign o_rdata = r_mem[i_raddr];
    end else begin : g_sync_rd
      logic [WIDTH-1:0] r_rdata;
      always_ff @(posedge i_clk) begin
        r_rdata <= r_mem[i_raddr];
      end
      assign o_rdata = r_rdata;
    end
  endgenerate

endmodule

// File: rtl/fifo_buffer_flags.sv
// Synchronous single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read mode.
// Ports: i_clk, i_rst (sync, active-high), i_wr_en/i_din, i_rd_en/o_dout, i_clr_err,
//        o_full, o_empty, o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow.
// Latency: FWFT=0 dout valid one cycle after rd_en; FWFT=1 head word visible the cycle after it is written.
module fifo_buffer_flags
  import fifo_buffer_flags_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = FIFO_STD
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_rd_en,
  input  logic                     i_clr_err,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full, r_empty, r_af, r_ae;
  logic             r_ovf, r_udf;
  logic [WIDTH-1:0] r_dout;

  logic             w_wr_acc, w_rd_acc;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_rd_data;

  // In standard mode a full FIFO can accept a write when a read frees the
  // same slot on this edge; in FWFT mode the write is refused instead.
  assign w_wr_acc = i_wr_en && (!r_full || (i_rd_en && (FWFT == FIFO_STD)));
  assign w_rd_acc = i_rd_en && !r_empty;

  assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

  fifo_buffer_flags_ram #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ASYNC_RD (1),
    .AW       (PW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_wr_en (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_dout   <= '0;
    end else begin
      // Pointer width equals log2(DEPTH), so +1 wraps DEPTH-1 -> 0 naturally.
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        // Captures the popped word; in FWFT mode this is the value held once empty.
        r_dout   <= w_rd_data;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= C_AF);
      r_ae    <= (w_count_nxt <= C_AE);
      // A fresh error in the same cycle as the clear leaves the flag set.
      r_ovf   <= (r_ovf && !i_clr_err) || (i_wr_en && !w_wr_acc);
      r_udf   <= (r_udf && !i_clr_err) || (i_rd_en && !w_rd_acc);
    end
  end

  // FWFT shows the head word straight from storage; pointer and memory are
  // both registered, so there is no path from rd_en/wr_en to dout.
  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      assign o_dout = r_empty ? r_dout : w_rd_data;
    end else begin : g_std
      assign o_dout = r_dout;
    end
  endgenerate

  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_af;
  assign o_almost_empty = r_ae;
  assign o_count        = r_count;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;

endmodule

// File: tb/tb_fifo_buffer_flags.sv
// Directed self-checking bench for fifo_buffer_flags: a standard-mode instance and an FWFT instance.
module tb_fifo_buffer_flags;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        wr, rd, f_wr, f_rd;
  logic [15:0] din, f_din;
  logic [15:0] dout, f_dout;
  logic        full, empty, af, ae, ovf, udf;
  logic        f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [5:0]  cnt, f_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_buffer_flags #(.WIDTH(16), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr), .i_din(din), .i_rd_en(rd), .i_clr_err(clr),
    .o_dout(dout), .o_full(full), .o_empty(empty), .o_almost_full(af),
    .o_almost_empty(ae), .o_count(cnt), .o_overflow(ovf), .o_underflow(udf)
  );

  fifo_buffer_flags #(.WIDTH(16), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(1)) u_dut_fw (
    .i_clk(clk), .i_rst(rst), .i_wr_en(f_wr), .i_din(f_din), .i_rd_en(f_rd), .i_clr_err(clr),
    .o_dout(f_dout), .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_af),
    .o_almost_empty(f_ae), .o_count(f_cnt), .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr = 0; rd = 0; clr = 0; f_wr = 0; f_rd = 0;
  endtask

  initial begin
    rst = 1; idle(); din = '0; f_din = '0;
    tick();
    rst = 0;
    // Reset state
    chk("rst_count", cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", ae, 1);
    chk("rst_af", af, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);

    // 1: fill with 0x0001..0x0020
    for (int i = 1; i <= 32; i++) begin
      wr = 1; din = 16'(i);
      tick();
      chk("fill_count", cnt, i);
      if (i == 4)  chk("fill_ae_at4", ae, 1);
      if (i == 5)  chk("fill_ae_at5", ae, 0);
      if (i == 27) chk("fill_af_at27", af, 0);
      if (i == 28) chk("fill_af_at28", af, 1);
    end
    chk("fill_full", full, 1);
    din = 16'h0099;
    tick();
    wr = 0;
    chk("ovf_set", ovf, 1);
    chk("ovf_count", cnt, 32);
    chk("ovf_full", full, 1);

    // 2: drain in order, standard read latency of one edge
    for (int i = 1; i <= 32; i++) begin
      rd = 1;
      tick();
      chk("drain_dout", dout, i);
      chk("drain_count", cnt, 32 - i);
    end
    chk("drain_empty", empty, 1);
    tick();
    rd = 0;
    chk("udf_set", udf, 1);
    chk("udf_dout_hold", dout, 16'h0020);
    chk("udf_ovf_sticky", ovf, 1);
    clr = 1;
    tick();
    clr = 0;
    chk("clr_ovf", ovf, 0);
    chk("clr_udf", udf, 0);

    // 3: two write/read rounds of 20 that wrap the pointers
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 20; i++) begin
        wr = 1; din = 16'(16'h0100 + r * 16'h0040 + i);
        tick();
      end
      wr = 0;
      chk("wrap_count20", cnt, 20);
      for (int i = 0; i < 20; i++) begin
        rd = 1;
        tick();
        chk("wrap_dout", dout, 16'h0100 + r * 16'h0040 + i);
      end
      rd = 0;
      chk("wrap_count0", cnt, 0);
    end
    chk("wrap_ovf", ovf, 0);
    chk("wrap_udf", udf, 0);

    // 4a: simultaneous read/write while full
    for (int i = 0; i < 32; i++) begin
      wr = 1; din = 16'(16'h0200 + i);
      tick();
    end
    rd = 1; din = 16'h02FF;
    tick();
    wr = 0; rd = 0;
    chk("rw_full_dout", dout, 16'h0200);
    chk("rw_full_count", cnt, 32);
    chk("rw_full_full", full, 1);
    chk("rw_full_ovf", ovf, 0);
    for (int i = 1; i <= 32; i++) begin
      rd = 1;
      tick();
      chk("rw_full_drain", dout, (i == 32) ? 16'h02FF : 16'h0200 + i);
    end
    rd = 0;
    chk("rw_full_empty", empty, 1);

    // 4b: simultaneous read/write while empty
    wr = 1; rd = 1; din = 16'h03AA;
    tick();
    wr = 0; rd = 0;
    chk("rw_empty_count", cnt, 1);
    chk("rw_empty_udf", udf, 1);
    chk("rw_empty_dout", dout, 16'h02FF);
    rd = 1;
    tick();
    rd = 0;
    chk("rw_empty_read", dout, 16'h03AA);
    chk("rw_empty_count0", cnt, 0);

    // 5: FWFT instance
    chk("fw_rst_empty", f_empty, 1);
    chk("fw_rst_dout", f_dout, 0);
    f_wr = 1; f_din = 16'hBEEF;
    tick();
    f_wr = 0;
    chk("fw_dout", f_dout, 16'hBEEF);
    chk("fw_empty", f_empty, 0);
    tick();
    chk("fw_dout_hold", f_dout, 16'hBEEF);
    f_rd = 1;
    tick();
    f_rd = 0;
    chk("fw_pop_empty", f_empty, 1);
    chk("fw_pop_count", f_cnt, 0);
    chk("fw_pop_udf", f_udf, 0);
    // FWFT full with simultaneous read/write: read wins, write refused
    for (int i = 0; i < 32; i++) begin
      f_wr = 1; f_din = 16'(16'h0500 + i);
      tick();
    end
    chk("fw_full", f_full, 1);
    chk("fw_head", f_dout, 16'h0500);
    f_rd = 1; f_din = 16'h05FF;
    tick();
    f_wr = 0; f_rd = 0;
    chk("fw_rw_count", f_cnt, 31);
    chk("fw_rw_ovf", f_ovf, 1);
    chk("fw_rw_head", f_dout, 16'h0501);

    // 6: reset mid-stream at count 17 (underflow still set from 4b)
    for (int i = 0; i < 17; i++) begin
      wr = 1; din = 16'(16'h0600 + i);
      tick();
    end
    chk("mid_count17", cnt, 17);
    chk("mid_udf_before", udf, 1);
    rd = 1; rst = 1;
    tick();
    rst = 0; wr = 0; rd = 0;
    chk("mid_rst_count", cnt, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ae", ae, 1);
    chk("mid_rst_udf", udf, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_fw_count", f_cnt, 0);
    chk("mid_rst_fw_ovf", f_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
